// File: rtl/alu_ctrl.sv
// Execute-stage controller: ID/EX register for ALU controls, branch/jump resolution and fetch redirect.
// Optional ALU_CTRL_PERF_EN adds perf_issued / perf_taken counters.
module alu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        ex_valid,
  output logic [2:0]  ALUOP,
  output logic        Asrc,
  output logic        Bsrc,
  output logic        sra,
  output logic        shdir,
  output logic        sub,
  output logic        jalr,
  output logic [31:0] imm,
  output logic [31:0] pc,
  output logic        rs1_zero,
  output logic        illegal,
  input  logic        EQ,
  input  logic        LT,
  input  logic        LTU,
  input  logic [31:0] BTA,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_taken
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]  d_aluop;
  logic        d_asrc, d_bsrc, d_sra, d_shdir, d_sub, d_jalr, d_rs1z, d_ill;
  logic        d_br, d_jal, d_jalr_k;
  logic [31:0] d_imm;

  // Resolution context kept alongside the visible controls
  logic        is_br, is_jal, is_jalr;
  logic [2:0]  br_f3;

  logic        br_cond, resolve, take, load;
  logic [31:0] tgt;

  assign opc   = id_instr[6:0];
  assign f3    = id_instr[14:12];
  assign imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
  assign imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign imm_b = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
  assign imm_u = {id_instr[31:12], 12'b0};
  assign imm_j = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};

  always_comb begin
    d_aluop = 3'b000; d_asrc = 1'b0; d_bsrc = 1'b0; d_sra = 1'b0; d_shdir = 1'b0;
    d_sub = 1'b0; d_jalr = 1'b0; d_rs1z = 1'b0; d_ill = 1'b0; d_imm = 32'd0;
    d_br = 1'b0; d_jal = 1'b0; d_jalr_k = 1'b0;
    case (opc)
      OPC_OP, OPC_OPIMM: begin
        d_aluop = f3;
        d_bsrc  = (opc == OPC_OPIMM);
        d_sub   = (opc == OPC_OP) && (f3 == 3'b000) && id_instr[30];
        d_sra   = (f3 == 3'b101) && id_instr[30];
        d_shdir = (f3 == 3'b001);
        d_imm   = (opc == OPC_OPIMM) ? imm_i : 32'd0;
      end
      OPC_LUI:    begin d_bsrc = 1'b1; d_rs1z = 1'b1; d_imm = imm_u; end
      OPC_AUIPC:  begin d_asrc = 1'b1; d_bsrc = 1'b1; d_imm = imm_u; end
      OPC_LOAD:   begin d_bsrc = 1'b1; d_imm = imm_i; end
      OPC_STORE:  begin d_bsrc = 1'b1; d_imm = imm_s; end
      OPC_BRANCH: begin d_sub = 1'b1; d_imm = imm_b; d_br = 1'b1; end
      OPC_JAL:    begin d_asrc = 1'b1; d_jalr = 1'b1; d_imm = imm_j; d_jal = 1'b1; end
      OPC_JALR:   begin d_asrc = 1'b1; d_jalr = 1'b1; d_imm = imm_i; d_jalr_k = 1'b1; end
      default:    d_ill = 1'b1;
    endcase
  end

  // LT/LTU arrive as less-or-equal, so strict compares mask out EQ
  always_comb begin
    case (br_f3)
      3'b000:  br_cond = EQ;
      3'b001:  br_cond = !EQ;
      3'b100:  br_cond = LT & !EQ;
      3'b101:  br_cond = !LT | EQ;
      3'b110:  br_cond = LTU & !EQ;
      3'b111:  br_cond = !LTU | EQ;
      default: br_cond = 1'b0;
    endcase
  end

  assign id_ready = !ex_valid | ex_ready;
  assign resolve  = ex_valid & ex_ready;
  assign take     = resolve & ((is_br & br_cond) | is_jal | is_jalr);
  assign load     = id_valid & id_ready;
  assign tgt      = is_jal ? (pc + imm) : is_jalr ? {BTA[31:1], 1'b0} : BTA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0; ALUOP <= 3'b000; Asrc <= 1'b0; Bsrc <= 1'b0; sra <= 1'b0;
      shdir <= 1'b0; sub <= 1'b0; jalr <= 1'b0; imm <= 32'd0; pc <= 32'd0;
      rs1_zero <= 1'b0; illegal <= 1'b0; redirect_valid <= 1'b0; redirect_pc <= 32'd0;
      is_br <= 1'b0; is_jal <= 1'b0; is_jalr <= 1'b0; br_f3 <= 3'b000;
    end else begin
      redirect_valid <= take & !flush;
      if (take & !flush) redirect_pc <= tgt;
      if (flush | take) begin
        ex_valid <= 1'b0;
      end else if (load) begin
        ex_valid <= 1'b1;
        ALUOP <= d_aluop; Asrc <= d_asrc; Bsrc <= d_bsrc; sra <= d_sra;
        shdir <= d_shdir; sub <= d_sub; jalr <= d_jalr; imm <= d_imm; pc <= id_pc;
        rs1_zero <= d_rs1z; illegal <= d_ill;
        is_br <= d_br; is_jal <= d_jal; is_jalr <= d_jalr_k; br_f3 <= f3;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= 32'd0;
      perf_taken  <= 32'd0;
    end else begin
      if (resolve) perf_issued <= perf_issued + 32'd1;
      if (take & !flush) perf_taken <= perf_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: instruction-level reference model compared every cycle,
// plus hand-computed expectations at the interesting points.
module tb_alu_ctrl;
  logic        clk, rst, id_valid, id_ready, ex_ready, flush, ex_valid;
  logic [31:0] id_instr, id_pc, imm, pc, BTA, redirect_pc;
  logic [2:0]  ALUOP;
  logic        Asrc, Bsrc, sra, shdir, sub, jalr, rs1_zero, illegal;
  logic        EQ, LT, LTU, redirect_valid;

  int n_vec = 0;
  int n_err = 0;

  alu_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid), .ALUOP(ALUOP),
    .Asrc(Asrc), .Bsrc(Bsrc), .sra(sra), .shdir(shdir), .sub(sub), .jalr(jalr), .imm(imm),
    .pc(pc), .rs1_zero(rs1_zero), .illegal(illegal), .EQ(EQ), .LT(LT), .LTU(LTU), .BTA(BTA),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 none, 1 branch, 2 JAL, 3 JALR
  typedef struct packed {
    logic [2:0]  aluop;
    logic        asrc, bsrc, sra, shdir, sub, jalr, rs1z, ill;
    logic [31:0] imm;
    logic [1:0]  kind;
    logic [2:0]  f3;
  } dec_t;

  function automatic dec_t decode(logic [31:0] i);
    dec_t d;
    logic [2:0] f;
    d = '0;
    f = i[14:12];
    case (i[6:0])
      7'h33: begin d.aluop = f; d.sub = (f == 0) && i[30]; d.sra = (f == 5) && i[30]; d.shdir = (f == 1); end
      7'h13: begin d.aluop = f; d.bsrc = 1; d.sra = (f == 5) && i[30]; d.shdir = (f == 1);
                   d.imm = 32'($signed(i[31:20])); end
      7'h37: begin d.bsrc = 1; d.rs1z = 1; d.imm = i & 32'hFFFFF000; end
      7'h17: begin d.asrc = 1; d.bsrc = 1; d.imm = i & 32'hFFFFF000; end
      7'h03: begin d.bsrc = 1; d.imm = 32'($signed(i[31:20])); end
      7'h23: begin d.bsrc = 1; d.imm = 32'($signed({i[31:25], i[11:7]})); end
      7'h63: begin d.sub = 1; d.kind = 1; d.f3 = f;
                   d.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'h6F: begin d.asrc = 1; d.jalr = 1; d.kind = 2;
                   d.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      7'h67: begin d.asrc = 1; d.jalr = 1; d.kind = 3; d.imm = 32'($signed(i[31:20])); end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  // Flags carry "less or equal"; strict less-than is le && !eq, and >= is its negation
  function automatic logic br_taken(logic [2:0] f, logic eq, logic le, logic leu);
    logic lt_s, lt_u;
    lt_s = le && !eq;
    lt_u = leu && !eq;
    case (f)
      0: return eq;
      1: return !eq;
      4: return lt_s;
      5: return !lt_s;
      6: return lt_u;
      7: return !lt_u;
      default: return 1'b0;
    endcase
  endfunction

  dec_t        m;
  logic [31:0] m_pc, m_rpc;
  logic        m_valid, m_rv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_rv = 0; m_rpc = 0; m = '0; m_pc = 0;
    end else begin
      logic        tk, can_take;
      logic [31:0] t;
      can_take = !m_valid || ex_ready;
      tk = 0; t = 0;
      if (m_valid && ex_ready) begin
        if (m.kind == 1 && br_taken(m.f3, EQ, LT, LTU)) begin tk = 1; t = BTA; end
        if (m.kind == 2) begin tk = 1; t = m_pc + m.imm; end
        if (m.kind == 3) begin tk = 1; t = BTA & ~32'd1; end
      end
      if (flush) begin
        m_rv = 0; m_valid = 0;
      end else begin
        m_rv = tk;
        if (tk) begin m_rpc = t; m_valid = 0; end
        else if (id_valid && can_take) begin m_valid = 1; m = decode(id_instr); m_pc = id_pc; end
        else if (ex_ready) m_valid = 0;
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_ex_valid", ex_valid, m_valid);
      chk("m_id_ready", id_ready, !m_valid || ex_ready);
      chk("m_redirect_valid", redirect_valid, m_rv);
      if (m_rv) chk("m_redirect_pc", redirect_pc, m_rpc);
      if (m_valid) begin
        chk("m_ctrl", {ALUOP, Asrc, Bsrc, sra, shdir, sub, jalr, rs1_zero, illegal},
            {m.aluop, m.asrc, m.bsrc, m.sra, m.shdir, m.sub, m.jalr, m.rs1z, m.ill});
        chk("m_imm", imm, m.imm);
        chk("m_pc", pc, m_pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [31:0] instr, logic [31:0] at_pc);
    id_valid = 1; id_instr = instr; id_pc = at_pc;
    step();
    id_valid = 0;
  endtask

  typedef struct packed {
    logic [31:0] instr;
    logic        eq, lt, ltu, taken;
  } bvec_t;

  bvec_t bv [5];

  initial begin
    rst = 1; id_valid = 0; id_instr = 0; id_pc = 0; ex_ready = 1; flush = 0;
    EQ = 0; LT = 0; LTU = 0; BTA = 0;
    #3;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_id_ready", id_ready, 1);
    chk("rst_redirect", {redirect_valid, redirect_pc}, 0);
    chk("rst_regs", {ALUOP, Asrc, Bsrc, sra, shdir, sub, jalr, rs1_zero, illegal, imm, pc}, 0);
    @(posedge clk); #1; rst = 0;
    step();

    issue(32'h00500093, 32'h100);  // ADDI x1,x0,5
    chk("addi_valid", ex_valid, 1);
    chk("addi_aluop_bsrc", {ALUOP, Bsrc}, {3'b000, 1'b1});
    chk("addi_imm", imm, 32'd5);
    chk("addi_pc", pc, 32'h100);
    step();
    chk("addi_no_redirect", redirect_valid, 0);

    issue(32'h4030D093, 32'h104);  // SRAI x1,x1,3
    chk("srai", {ALUOP, sra, shdir}, {3'b101, 1'b1, 1'b0});
    issue(32'h402081B3, 32'h108);  // SUB x3,x1,x2
    chk("sub", {ALUOP, sub, Bsrc}, {3'b000, 1'b1, 1'b0});
    issue(32'h00209093, 32'h10C);  // SLLI x1,x1,2
    chk("slli", {ALUOP, shdir, sra}, {3'b001, 1'b1, 1'b0});
    issue(32'hFFC12083, 32'h110);  // LW x1,-4(x2)
    chk("lw_imm", imm, 32'hFFFFFFFC);
    issue(32'h00312423, 32'h114);  // SW x3,8(x2)
    chk("sw_imm", imm, 32'd8);
    issue(32'h123452B7, 32'h118);  // LUI x5,0x12345
    chk("lui", {rs1_zero, Asrc, Bsrc, imm}, {1'b1, 1'b0, 1'b1, 32'h12345000});
    issue(32'h00001297, 32'h11C);  // AUIPC x5,1
    chk("auipc", {Asrc, Bsrc, imm}, {1'b1, 1'b1, 32'h00001000});
    step();

    // BLT resolves taken; the ADDI offered on the same edge is squashed
    issue(32'h0020C863, 32'h200);
    chk("blt_imm", imm, 32'h10);
    EQ = 0; LT = 1; BTA = 32'h210;
    id_valid = 1; id_instr = 32'h00500093; id_pc = 32'h204;
    step();
    id_valid = 0; LT = 0;
    chk("blt_redirect", {redirect_valid, redirect_pc}, {1'b1, 32'h210});
    chk("blt_squash", ex_valid, 0);
    step();
    chk("blt_pulse_1cyc", redirect_valid, 0);

    issue(32'h0020D863, 32'h300);  // BGE, EQ=1 LT=1 -> taken
    EQ = 1; LT = 1; BTA = 32'h340;
    step();
    chk("bge_taken", {redirect_valid, redirect_pc}, {1'b1, 32'h340});
    EQ = 0; LT = 0;
    step();

    issue(32'h0020E863, 32'h400);  // BLTU, EQ=1 LTU=1 -> not taken
    EQ = 1; LTU = 1;
    step();
    chk("bltu_not_taken", redirect_valid, 0);
    EQ = 0; LTU = 0;
    step();

    bv[0] = {32'h00208863, 1'b0, 1'b0, 1'b0, 1'b0};  // BEQ, not equal
    bv[1] = {32'h00209863, 1'b0, 1'b1, 1'b1, 1'b1};  // BNE, not equal
    bv[2] = {32'h0020A863, 1'b1, 1'b1, 1'b1, 1'b0};  // funct3 010, never
    bv[3] = {32'h0020F863, 1'b0, 1'b0, 1'b1, 1'b0};  // BGEU, strictly below
    bv[4] = {32'h0020C863, 1'b1, 1'b1, 1'b0, 1'b0};  // BLT, equal
    for (int k = 0; k < 5; k++) begin
      issue(bv[k].instr, 32'h500);
      EQ = bv[k].eq; LT = bv[k].lt; LTU = bv[k].ltu; BTA = 32'h600;
      step();
      chk("bvec_taken", redirect_valid, bv[k].taken);
      if (bv[k].taken) chk("bvec_target", redirect_pc, 32'h600);
      EQ = 0; LT = 0; LTU = 0;
      step();
    end

    issue(32'h001000EF, 32'h1000);  // JAL x1,+0x800
    chk("jal_ctrl", {jalr, Asrc, imm}, {1'b1, 1'b1, 32'h800});
    BTA = 32'hDEAD;
    step();
    chk("jal_redirect", {redirect_valid, redirect_pc}, {1'b1, 32'h1800});
    step();

    issue(32'h000100E7, 32'h2000);  // JALR x1,0(x2), stalled 3 cycles
    ex_ready = 0; BTA = 32'h305;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("jalr_stall", {redirect_valid, ex_valid, id_ready, jalr, Asrc, pc},
          {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2000});
    end
    ex_ready = 1;
    step();
    chk("jalr_redirect", {redirect_valid, redirect_pc}, {1'b1, 32'h304});
    step();

    issue(32'h00208863, 32'h700);  // BEQ taken but flushed
    EQ = 1; BTA = 32'h710; flush = 1;
    step();
    chk("flush_redirect", redirect_valid, 0);
    chk("flush_valid", ex_valid, 0);
    flush = 0; EQ = 0;
    step();
    chk("flush_no_late", redirect_valid, 0);

    issue(32'h00000000, 32'h800);  // unsupported opcode
    chk("illegal", {illegal, ALUOP, Asrc, Bsrc, sub, jalr, imm}, {1'b1, 3'b000, 4'b0000, 32'd0});
    step();
    chk("illegal_no_redirect", redirect_valid, 0);

    issue(32'h001000EF, 32'h1000);  // reset while the redirect pulse is high
    step();
    chk("pre_rst_redirect", redirect_valid, 1);
    #2 rst = 1;
    #1;
    chk("async_rst", {redirect_valid, redirect_pc, ex_valid, imm, pc}, 0);
    @(posedge clk); #1; rst = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
